// File: rtl/iota_step_if.sv
// Slice-memory port shared by the Keccak step engines (chi, iota).
// Latency: none, wires only; read data returns one cycle after mem_r.
// Backpressure: none; the memory accepts one access per cycle.
interface iota_step_if;
  logic [5:0]  mem_adr;  // slice address z
  logic [0:24] mem_in;   // slice write data, bit i = lane 5y+x
  logic        mem_r;    // read strobe
  logic        mem_w;    // write strobe
  logic [0:24] in;       // slice read data, valid the cycle after mem_r

  modport master (output mem_adr, output mem_in, output mem_r, output mem_w, input in);
  modport slave  (input mem_adr, input mem_in, input mem_r, input mem_w, output in);
endinterface

// File: rtl/iota_step.sv
// Keccak-f[1600] iota: XOR RC[round][z] into lane (0,0) of every slice z.
// Latency: 2 cycles per slice visited (128 full sweep, 14 with IOTA_SPARSE_SWEEP_EN).
// Backpressure: none; start is a level request, done is held until start drops.
module iota_step #(
  parameter int SLICES = 64,
  parameter int ROUNDS = 24
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [4:0]    round_idx,
  iota_step_if.master   mem,
  output logic          done,
  output logic          bad_round
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [5:0] LAST_Z  = 6'(SLICES - 1);
  localparam logic [5:0] NROUNDS = 6'(ROUNDS);

  state_t      state_q, state_d;
  logic [5:0]  z_q, z_d;
  logic [6:0]  rc_q, rc_d;   // RC bits at z = 2^j-1, j = 0..6
  logic        bad_q, bad_d;
  logic        round_bad;
  logic        rc_bit;
  logic [5:0]  z_next;

  // Only slices 0,1,3,7,15,31,63 can carry a nonzero RC bit, so the ROM
  // stores just those seven bits per round.
  function automatic logic [6:0] rc_rom(input logic [4:0] r);
    case (r)
      5'd0:    rc_rom = 7'h01;
      5'd1:    rc_rom = 7'h1A;
      5'd2:    rc_rom = 7'h5E;
      5'd3:    rc_rom = 7'h70;
      5'd4:    rc_rom = 7'h1F;
      5'd5:    rc_rom = 7'h21;
      5'd6:    rc_rom = 7'h79;
      5'd7:    rc_rom = 7'h55;
      5'd8:    rc_rom = 7'h0E;
      5'd9:    rc_rom = 7'h0C;
      5'd10:   rc_rom = 7'h35;
      5'd11:   rc_rom = 7'h26;
      5'd12:   rc_rom = 7'h3F;
      5'd13:   rc_rom = 7'h4F;
      5'd14:   rc_rom = 7'h5D;
      5'd15:   rc_rom = 7'h53;
      5'd16:   rc_rom = 7'h52;
      5'd17:   rc_rom = 7'h48;
      5'd18:   rc_rom = 7'h16;
      5'd19:   rc_rom = 7'h66;
      5'd20:   rc_rom = 7'h79;
      5'd21:   rc_rom = 7'h58;
      5'd22:   rc_rom = 7'h21;
      5'd23:   rc_rom = 7'h74;
      default: rc_rom = 7'h00;
    endcase
  endfunction

  // Pick the stored RC bit for the current slice; all other slices get 0.
  always_comb begin
    rc_bit = 1'b0;
    case (z_q)
      6'd0:    rc_bit = rc_q[0];
      6'd1:    rc_bit = rc_q[1];
      6'd3:    rc_bit = rc_q[2];
      6'd7:    rc_bit = rc_q[3];
      6'd15:   rc_bit = rc_q[4];
      6'd31:   rc_bit = rc_q[5];
      6'd63:   rc_bit = rc_q[6];
      default: rc_bit = 1'b0;
    endcase
  end

  assign round_bad = ({1'b0, round_idx} >= NROUNDS);

  // Sparse mode walks z = 2^j-1 by shifting in a one; full mode counts up.
`ifdef IOTA_SPARSE_SWEEP_EN
  assign z_next = {z_q[4:0], 1'b1};
`else
  assign z_next = z_q + 6'd1;
`endif

  // Next-state and Moore outputs; memory strobes depend only on state.
  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    rc_d        = rc_q;
    bad_d       = bad_q;
    mem.mem_adr = 6'd0;
    mem.mem_in  = 25'd0;
    mem.mem_r   = 1'b0;
    mem.mem_w   = 1'b0;
    done        = 1'b0;
    bad_round   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rc_d    = round_bad ? 7'h00 : rc_rom(round_idx);
          bad_d   = round_bad;
          z_d     = 6'd0;
          state_d = READ;
        end
      end
      READ: begin
        mem.mem_r   = 1'b1;
        mem.mem_adr = z_q;
        state_d     = WRITE;
      end
      WRITE: begin
        mem.mem_w     = 1'b1;
        mem.mem_adr   = z_q;
        mem.mem_in    = mem.in;
        mem.mem_in[0] = mem.in[0] ^ rc_bit;
        if (z_q == LAST_Z) begin
          state_d = DONE;
        end else begin
          z_d     = z_next;
          state_d = READ;
        end
      end
      DONE: begin
        done      = 1'b1;
        bad_round = bad_q;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts a sweep on the spot.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      z_q     <= 6'd0;
      rc_q    <= 7'h00;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      rc_q    <= rc_d;
      bad_q   <= bad_d;
    end
  end

endmodule

// File: tb/tb_iota_step.sv
// Bench for iota_step: slice memory model, write/done scoreboard, directed rounds.
module tb_iota_step;

`ifdef IOTA_SPARSE_SWEEP_EN
  localparam int N_VISIT   = 7;
  localparam int EXP_DONE  = 14;
  localparam int ABORT_CYC = 6;
`else
  localparam int N_VISIT   = 64;
  localparam int EXP_DONE  = 128;
  localparam int ABORT_CYC = 40;
`endif

  typedef struct {
    logic [5:0]  adr;
    logic [0:24] dat;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  round_idx;
  logic        done;
  logic        bad_round;

  logic        load = 1'b0;
  logic [0:24] init_val = 25'd0;
  logic [0:24] mem [64];
  logic [0:24] exp_mem [64];

  wr_t         wq[$];
  bit          dq[$];

  int          checks = 0;
  int          errors = 0;

  logic        prev_r = 1'b0;
  logic [5:0]  prev_adr = 6'd0;
  logic        prev_done = 1'b0;

  iota_step_if mem_bus();

  iota_step #(.SLICES(64), .ROUNDS(24)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .round_idx (round_idx),
    .mem       (mem_bus),
    .done      (done),
    .bad_round (bad_round)
  );

  always #5 clock = ~clock;

  // Synchronous-read slice memory.
  always @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val;
    end else begin
      if (mem_bus.mem_w) mem[mem_bus.mem_adr] <= mem_bus.mem_in;
      if (mem_bus.mem_r) mem_bus.in <= mem[mem_bus.mem_adr];
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic int visit_z(input int i);
`ifdef IOTA_SPARSE_SWEEP_EN
    return (1 << i) - 1;
`else
    return i;
`endif
  endfunction

  // Monitor: pops expected writes and done events as the DUT presents them.
  always @(negedge clock) begin
    wr_t e;
    bit  eb;
    if (mem_bus.mem_r || mem_bus.mem_w)
      check("rw_exclusive", 64'(mem_bus.mem_r & mem_bus.mem_w), 64'd0);
    if (mem_bus.mem_w) begin
      check("write_follows_read", 64'({prev_r, prev_adr}), 64'({1'b1, mem_bus.mem_adr}));
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write adr=%0d dat=%0h", mem_bus.mem_adr, mem_bus.mem_in);
      end else begin
        e = wq.pop_front();
        check("write_adr", 64'(mem_bus.mem_adr), 64'(e.adr));
        check("write_dat", 64'(mem_bus.mem_in), 64'(e.dat));
      end
    end
    if (done && !prev_done) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done bad_round=%0b", bad_round);
      end else begin
        eb = dq.pop_front();
        check("bad_round_at_done", 64'(bad_round), 64'(eb));
      end
    end
    prev_r    = mem_bus.mem_r;
    prev_adr  = mem_bus.mem_adr;
    prev_done = done;
  end

  // One sweep: load memory, queue expectations, run, then check timing and memory.
  task automatic run_sweep(input logic [4:0] rnd, input logic [0:24] init,
                           input logic [63:0] flip, input bit exp_bad,
                           input int abort_cyc, input bit drop);
    int nw;
    int got;
    bit aborted;
    wr_t e;
    @(negedge clock);
    init_val = init;
    load     = 1'b1;
    @(negedge clock);
    load = 1'b0;

    nw = (abort_cyc > 0) ? ((abort_cyc - 2) / 2 + 1) : N_VISIT;
    for (int i = 0; i < 64; i++) exp_mem[i] = init;
    for (int i = 0; i < nw; i++) begin
      e.adr = 6'(visit_z(i));
      e.dat = init;
      if (flip[visit_z(i)]) e.dat[0] = ~e.dat[0];
      exp_mem[visit_z(i)] = e.dat;
      wq.push_back(e);
    end
    if (abort_cyc == 0) dq.push_back(exp_bad);

    round_idx = rnd;
    start     = 1'b1;
    @(posedge clock);
    #1;
    round_idx = ~rnd;

    got = 0;
    aborted = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (drop && k == 10) start = 1'b0;
      if (abort_cyc > 0 && k == abort_cyc) begin
        reset = 1'b0;
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      if (abort_cyc > 0 && k == abort_cyc) begin
        check("abort_outputs", 64'({done, bad_round, mem_bus.mem_r, mem_bus.mem_w,
                                    mem_bus.mem_adr, mem_bus.mem_in}), 64'd0);
        reset   = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (done) begin
        got = k;
        break;
      end
    end

    if (aborted) begin
      check("abort_no_pending_writes", 64'(wq.size()), 64'd0);
    end else begin
      check("done_cycle", 64'(got), 64'(EXP_DONE));
      if (!drop) begin
        repeat (2) begin
          @(posedge clock);
          #1;
        end
        check("done_held", 64'({done, bad_round}), 64'({1'b1, exp_bad}));
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      check("done_release", 64'({done, bad_round}), 64'd0);
    end

    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin
        errors++;
        $display("FAIL mem_slice z=%0d got=%0h want=%0h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    round_idx = 5'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", 64'({done, bad_round, mem_bus.mem_r, mem_bus.mem_w,
                                mem_bus.mem_adr, mem_bus.mem_in}), 64'd0);
    reset = 1'b1;

    // Round 0, zero memory: only slice 0 bit 0 set.
    run_sweep(5'd0, 25'h0000000, 64'h0000000000000001, 1'b0, 0, 1'b0);
    // Round 1, all-ones memory: bit 0 cleared in slices 1, 7, 15.
    run_sweep(5'd1, 25'h1FFFFFF, 64'h0000000000008082, 1'b0, 0, 1'b0);
    // Round 23, zero memory, start dropped mid-sweep: slices 3, 15, 31, 63.
    run_sweep(5'd23, 25'h0000000, 64'h8000000080008008, 1'b0, 0, 1'b1);
    // Out-of-range round: data unchanged, bad_round with done.
    run_sweep(5'd24, 25'h1555555, 64'h0000000000000000, 1'b1, 0, 1'b0);
    // Reset mid-sweep, then a fresh sweep from slice 0.
    run_sweep(5'd23, 25'h0000000, 64'h8000000080008008, 1'b0, ABORT_CYC, 1'b0);
    run_sweep(5'd0, 25'h0000000, 64'h0000000000000001, 1'b0, 0, 1'b0);

    check("write_queue_drained", 64'(wq.size()), 64'd0);
    check("done_queue_drained", 64'(dq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iota_step.md
# iota_step

Keccak-f[1600] iota step, the stage directly downstream of the chi (Revaluate) step in the SHA-3 round datapath. It sweeps the slice-organised state memory (64 slices × 25 bits, one slice per address) and XORs the round constant bit RC[round][z] into lane (0,0) of each slice z. It uses the same memory port style as its chi neighbour and hands back a level `done` to the round controller.

## Interface
Parameters:
- `SLICES`, 64: number of slices swept; also the memory depth.
- `ROUNDS`, 24: number of valid round indices.

Ports:
- `clock`  in  1  rising-edge clock; the only clock in the block.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  level request; sampled only in IDLE.
- `round_idx`  in  5  round number. Sampled with `start`.
- `in`  in  [0:24]  slice read data, bit i = lane (x,y) with i = 5y+x.
- `mem_adr`  out  6  slice address z.
- `mem_in`  out  [0:24]  slice write data.
- `mem_r`  out  1  read strobe.
- `mem_w`  out  1  write strobe.
- `done`  out  1  sweep complete; held in DONE.
- `bad_round`  out  1  `round_idx` ≥ ROUNDS was captured; valid while `done`=1.

## Operation
- Internal 24-entry ROM holds a 7-bit vector per round: bit j = RC bit at slice z = 2^j−1, for j = 0..6 (z ∈ {0,1,3,7,15,31,63}). All other RC bits are 0 by definition.
- Out-of-range round (≥ 24): constant treated as all-zero. The sweep still runs, data passes unchanged, and `bad_round`=1.
- FSM states are IDLE, READ, WRITE and DONE.
  - IDLE: when `start`=1, capture `round_idx`, set z to the first slice, and go to READ.
  - READ: `mem_r`=1, `mem_adr`=z. Go to WRITE.
  - WRITE: `mem_w`=1, `mem_adr`=z, `mem_in`=`in` with bit 0 XORed with RC bit z; bits 1..24 pass unchanged.
    - If z is the last slice, go to DONE.
    - Otherwise advance z and go to READ.
  - DONE: `done`=1. When `start`=0, go to IDLE; otherwise hold.
- Memory is synchronous read: `in` is valid in the cycle after the `mem_r` cycle, i.e. during WRITE.
- `mem_r` and `mem_w` are never high together.
- Slice counter is 6 bits. The last slice is 63 and the counter never wraps mid-sweep.

## Timing
- Reset (`reset`=0 at a rising edge): state IDLE; `done`, `bad_round`, `mem_r`, `mem_w`, `mem_adr`, `mem_in` all 0. Reset mid-sweep aborts immediately with no further writes. Slices already written stay modified.
- Edge E0 samples `start`=1 in IDLE. The sweep takes 2 cycles per slice.
  - Full sweep: READ z=0 in cycle 1, WRITE z=0 in cycle 2, …, WRITE z=63 in cycle 128.
  - `done` rises after E128 and stays high while `start`=1.
- `start` dropping mid-sweep is ignored; the sweep completes. If `start`=0 on entry to DONE, `done` is high for exactly one cycle, then IDLE.
- Re-trigger needs `start` low for at least one cycle (DONE→IDLE) before it is raised again.
- `round_idx` changes after E0 have no effect.

## Configuration
- `IOTA_SPARSE_SWEEP_EN`
  - Defined: only the 7 slices {0,1,3,7,15,31,63} are visited, in ascending order, with the same READ/WRITE pair per slice. `done` rises after E14. All other slices are never accessed.
  - Undefined: all 64 slices are read and rewritten; `done` rises after E128.
  - Memory contents after the sweep are identical in both modes.

## Test plan
- Round 0 with the memory holding all-zero slices, full sweep → slice 0 bit 0 = 1. All other slices remain 0. `done` rises after E128. `bad_round`=0.
- Round 1 (RC 0x0000000000008082) with every slice = 25'h1FFFFFF → slices 1, 7 and 15 read 25'h0FFFFFF (bit 0 cleared); every other slice is unchanged.
- Round 23 (RC 0x8000000080008008) with zero memory → bit 0 set in slices 3, 15, 31 and 63 only. Check `mem_r`/`mem_w` alternate and are never both high.
- `round_idx`=24 → memory unchanged, `bad_round`=1 together with `done`. Then `start` low → `done`=0 and `bad_round`=0 next cycle.
- Assert reset low at cycle 40 of a sweep → all outputs 0 on the next cycle. Slices ≥ 20 are not written. A fresh `start` restarts from slice 0.
- With `IOTA_SPARSE_SWEEP_EN` defined, run round 1 → same memory result as the round-1 case. Exactly 7 writes, with `mem_adr` sequence 0, 1, 3, 7, 15, 31, 63. `done` rises after E14.
